// File: rtl/wb_stage_ext.sv
// rtl/wb_stage_ext.sv - MEM/WB pipeline register and writeback unit with load extraction
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_ext #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_valid,
  output logic                  m_ready,
  input  logic                  flush,
  input  logic                  reg_wem,
  input  logic [REG_ADDR_W-1:0] rdm,
  input  logic [ADDR_WIDTH-1:0] pcnm,
  input  logic [DATA_WIDTH-1:0] alu_resultm,
  input  logic [DATA_WIDTH-1:0] extm,
  input  logic [1:0]            wb_ctrm,
  input  logic [2:0]            ld_sizem,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  reg_wew,
  output logic [REG_ADDR_W-1:0] rdw,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  wb_busy
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           retire_cnt
`endif
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WAIT_LD = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  reg_wew_q, reg_wew_d;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]           retire_cnt_q, retire_cnt_d;
`endif

  // Byte lanes are picked with indexed part-selects so the offset never exceeds the word.
  function automatic logic [DATA_WIDTH-1:0] extract_load(
    input logic [DATA_WIDTH-1:0] d,
    input logic [OFF_W-1:0]      off,
    input logic [2:0]            sz
  );
    logic [OFF_W-1:0]      off_h;
    logic [OFF_W-1:0]      off_w;
    logic [7:0]            b;
    logic [15:0]           h;
    logic [31:0]           w;
    logic [DATA_WIDTH-1:0] r;
    off_h = off & ~OFF_W'(1);
    off_w = off & ~OFF_W'(3);
    b     = d[{off, 3'b000} +: 8];
    h     = d[{off_h, 3'b000} +: 16];
    w     = d[{off_w, 3'b000} +: 32];
    case (sz)
      3'b000:  r = DATA_WIDTH'($signed(b));
      3'b100:  r = DATA_WIDTH'(b);
      3'b001:  r = DATA_WIDTH'($signed(h));
      3'b101:  r = DATA_WIDTH'(h);
      3'b010:  r = DATA_WIDTH'($signed(w));
      3'b110:  r = (DATA_WIDTH == 64) ? DATA_WIDTH'(w) : d;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] select_result(
    input logic [1:0]            ctr,
    input logic [DATA_WIDTH-1:0] alu,
    input logic [ADDR_WIDTH-1:0] pcn,
    input logic [DATA_WIDTH-1:0] ext
  );
    logic [DATA_WIDTH-1:0] r;
    case (ctr)
      2'b01:   r = DATA_WIDTH'(pcn);
      2'b10:   r = ext;
      default: r = alu;
    endcase
    return r;
  endfunction

  assign m_ready = (state_q != WAIT_LD);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    rd_d     = rd_q;
    off_d    = off_q;
    size_d   = size_q;
    result_d = result_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (m_valid && m_ready) begin
      we_d   = reg_wem;
      rd_d   = rdm;
      off_d  = alu_resultm[OFF_W-1:0];
      size_d = ld_sizem;
      if (wb_ctrm != 2'b11) begin
        state_d  = WRITE;
        result_d = select_result(wb_ctrm, alu_resultm, pcnm, extm);
      end else if (data_valid) begin
        state_d  = WRITE;
        result_d = extract_load(data_out, alu_resultm[OFF_W-1:0], ld_sizem);
      end else begin
        state_d = WAIT_LD;
      end
    end else begin
      case (state_q)
        WAIT_LD: begin
          if (data_valid) begin
            state_d  = WRITE;
            result_d = extract_load(data_out, off_q, size_q);
          end
        end
        WRITE:   state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
    reg_wew_d = (state_d == WRITE) && we_d && (rd_d != '0);
  end

`ifdef WB_RETIRE_CNT_EN
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (state_q == WRITE) retire_cnt_d = retire_cnt_q + 64'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      we_q         <= 1'b0;
      rd_q         <= '0;
      off_q        <= '0;
      size_q       <= '0;
      result_q     <= '0;
      reg_wew_q    <= 1'b0;
`ifdef WB_RETIRE_CNT_EN
      retire_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      off_q        <= off_d;
      size_q       <= size_d;
      result_q     <= result_d;
      reg_wew_q    <= reg_wew_d;
`ifdef WB_RETIRE_CNT_EN
      retire_cnt_q <= retire_cnt_d;
`endif
    end
  end

  assign reg_wew = reg_wew_q;
  assign rdw     = rd_q;
  assign result  = result_q;
  assign wb_busy = (state_q == WAIT_LD);
`ifdef WB_RETIRE_CNT_EN
  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_ext.sv
// tb/tb_wb_stage_ext.sv - directed self-checking bench for wb_stage_ext (32-bit datapath)
module tb_wb_stage_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic        m_ready;
  logic        flush;
  logic        reg_wem;
  logic [4:0]  rdm;
  logic [31:0] pcnm;
  logic [31:0] alu_resultm;
  logic [31:0] extm;
  logic [1:0]  wb_ctrm;
  logic [2:0]  ld_sizem;
  logic        data_valid;
  logic [31:0] data_out;
  logic        reg_wew;
  logic [4:0]  rdw;
  logic [31:0] result;
  logic        wb_busy;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  wb_stage_ext dut (
    .clk         (clk),
    .rst         (rst),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .flush       (flush),
    .reg_wem     (reg_wem),
    .rdm         (rdm),
    .pcnm        (pcnm),
    .alu_resultm (alu_resultm),
    .extm        (extm),
    .wb_ctrm     (wb_ctrm),
    .ld_sizem    (ld_sizem),
    .data_valid  (data_valid),
    .data_out    (data_out),
    .reg_wew     (reg_wew),
    .rdw         (rdw),
    .result      (result),
    .wb_busy     (wb_busy)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ctr, input logic [2:0] sz, input logic [4:0] rd,
                      input logic [31:0] alu, input logic dv, input logic [31:0] dout);
    m_valid     = 1'b1;
    reg_wem     = 1'b1;
    wb_ctrm     = ctr;
    ld_sizem    = sz;
    rdm         = rd;
    alu_resultm = alu;
    data_valid  = dv;
    data_out    = dout;
  endtask

  task automatic quiet();
    m_valid    = 1'b0;
    flush      = 1'b0;
    data_valid = 1'b0;
  endtask

  // Load vectors with immediate data: size, offset, raw data, expected result.
  logic [2:0]  ld_sz  [6] = '{3'b101, 3'b001, 3'b100, 3'b010, 3'b110, 3'b011};
  logic [31:0] ld_adr [6] = '{32'h2, 32'h2, 32'h1, 32'h1, 32'h0, 32'h3};
  logic [31:0] ld_dat [6] = '{32'hBEEF0000, 32'hBEEF0000, 32'h0000A500,
                              32'h87654321, 32'hCAFEF00D, 32'h12345678};
  logic [31:0] ld_exp [6] = '{32'h0000BEEF, 32'hFFFFBEEF, 32'h000000A5,
                              32'h87654321, 32'hCAFEF00D, 32'h12345678};

  initial begin
    rst = 1'b0; m_valid = 0; flush = 0; reg_wem = 0; rdm = 0; pcnm = 0;
    alu_resultm = 0; extm = 0; wb_ctrm = 0; ld_sizem = 0; data_valid = 0; data_out = 0;
    #12;
    chk("rst_reg_wew", reg_wew, 0);
    chk("rst_rdw", rdw, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", wb_busy, 0);
    chk("rst_m_ready", m_ready, 1);
    rst = 1'b1;
    cyc();

    send(2'b00, 3'b000, 5'd5, 32'h1234, 1'b0, 32'h0);
    cyc(); quiet();
    chk("alu_wew", reg_wew, 1);
    chk("alu_rdw", rdw, 5);
    chk("alu_result", result, 32'h1234);
    cyc();
    chk("alu_idle_wew", reg_wew, 0);
    chk("alu_idle_hold", result, 32'h1234);

    send(2'b11, 3'b000, 5'd7, 32'h3, 1'b0, 32'h0);
    cyc(); m_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lb_wait_busy%0d", i), wb_busy, 1);
      chk($sformatf("lb_wait_ready%0d", i), m_ready, 0);
      chk($sformatf("lb_wait_wew%0d", i), reg_wew, 0);
      if (i < 2) cyc();
    end
    data_valid = 1; data_out = 32'h80FFFFFF;
    cyc(); quiet();
    chk("lb_wew", reg_wew, 1);
    chk("lb_result", result, 32'hFFFFFF80);
    chk("lb_busy", wb_busy, 0);

    for (int i = 0; i < 6; i++) begin
      send(2'b11, ld_sz[i], 5'd8, ld_adr[i], 1'b1, ld_dat[i]);
      cyc();
      chk($sformatf("ld%0d_wew", i), reg_wew, 1);
      chk($sformatf("ld%0d_result", i), result, ld_exp[i]);
    end
    quiet(); cyc();

    send(2'b00, 3'b000, 5'd0, 32'h55, 1'b0, 32'h0);
    cyc(); quiet();
    chk("x0_wew", reg_wew, 0);
    chk("x0_result", result, 32'h55);
    send(2'b00, 3'b000, 5'd3, 32'h66, 1'b0, 32'h0);
    reg_wem = 0;
    cyc(); quiet();
    chk("nowe_wew", reg_wew, 0);

    send(2'b01, 3'b000, 5'd1, 32'h0, 1'b0, 32'h0);
    pcnm = 32'h104;
    cyc();
    chk("link_result", result, 32'h104);
    chk("link_wew", reg_wew, 1);
    send(2'b10, 3'b000, 5'd2, 32'h0, 1'b0, 32'h0);
    extm = 32'hABCD0000;
    cyc(); quiet();
    chk("ext_result", result, 32'hABCD0000);

    send(2'b11, 3'b010, 5'd9, 32'h0, 1'b0, 32'h0);
    cyc(); m_valid = 0;
    chk("fl_busy", wb_busy, 1);
    flush = 1;
    cyc(); flush = 0;
    chk("fl_busy_after", wb_busy, 0);
    chk("fl_m_ready", m_ready, 1);
    chk("fl_wew", reg_wew, 0);
    data_valid = 1; data_out = 32'h11;
    cyc(); quiet();
    chk("fl_late_dv_wew", reg_wew, 0);
    chk("fl_late_dv_result", result, 32'hABCD0000);

    send(2'b00, 3'b000, 5'd4, 32'h77, 1'b0, 32'h0);
    flush = 1;
    cyc(); quiet();
    chk("fl_accept_wew", reg_wew, 0);

    send(2'b11, 3'b000, 5'd6, 32'h0, 1'b0, 32'h0);
    cyc(); quiet();
    chk("rst_mid_pre_busy", wb_busy, 1);
    rst = 0;
    #1;
    chk("rst_mid_busy", wb_busy, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_rdw", rdw, 0);
    cyc();
    rst = 1;

    for (int i = 0; i < 4; i++) begin
      send(2'b00, 3'b000, 5'(10 + i), 32'h100 + i, 1'b0, 32'h0);
      cyc();
      chk($sformatf("b2b%0d_wew", i), reg_wew, 1);
      chk($sformatf("b2b%0d_result", i), result, 32'h100 + i);
    end
    quiet(); cyc();
    chk("b2b_idle_wew", reg_wew, 0);
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
